// File: rtl/alu_issue_queue.sv
// alu_issue_queue
// Two-entry FIFO sitting between decode and the ALU. Instructions are fully
// decoded into ALU issue packets as they are accepted, so the execute stage
// only sees ready-made operands and control bits straight from registers.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous discard of every queued entry
//   in_valid/in_ready : decode-side handshake
//   in_instr          : raw 16-bit instruction word
//   in_rs/in_rt/in_imm: Rs data, Rt data, extended immediate
//   out_valid/ex_ready: execute-side handshake
//   A, B              : ALU operands of the head entry
//   Op                : head instruction word, forwarded unmodified
//   Cin/invA/invB/sign: ALU control bits of the head entry
module alu_issue_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_rs,
    input  logic [15:0] in_rt,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        ex_ready,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [15:0] Op,
    output logic        Cin,
    output logic        invA,
    output logic        invB,
    output logic        sign
);

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] op;
        logic        cin;
        logic        inv_a;
        logic        inv_b;
        logic        sign;
    } packet_t;

    packet_t    mem [2];
    packet_t    decoded;
    packet_t    head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_enq;
    logic       do_deq;

    // Handshakes depend only on registered occupancy, never on ex_ready,
    // so a full queue refuses input even while the head is draining.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign do_enq    = in_valid & in_ready;
    assign do_deq    = out_valid & ex_ready;

    // Decode at enqueue time. Opcodes not listed fall through to the
    // defaults (A=rs, B=imm, no inversion, signed).
    always_comb begin
        decoded       = '0;
        decoded.a     = in_rs;
        decoded.b     = in_imm;
        decoded.op    = in_instr;
        decoded.sign  = 1'b1;
        case (in_instr[15:11])
            5'b01001: begin
                decoded.inv_a = 1'b1;
                decoded.cin   = 1'b1;
            end
            5'b01011: decoded.inv_b = 1'b1;
            5'b10010: decoded.a = {in_rs[7:0], 8'h00};
            5'b11010: decoded.b = in_rt;
            5'b11011: begin
                decoded.b = in_rt;
                case (in_instr[1:0])
                    2'b01: begin
                        decoded.inv_a = 1'b1;
                        decoded.cin   = 1'b1;
                    end
                    2'b11:   decoded.inv_b = 1'b1;
                    default: ;
                endcase
            end
            5'b11100, 5'b11101, 5'b11110: begin
                decoded.b     = in_rt;
                decoded.inv_b = 1'b1;
                decoded.cin   = 1'b1;
            end
            5'b11111: begin
                decoded.b    = in_rt;
                decoded.sign = 1'b0;
            end
            default: ;
        endcase
    end

    // Storage, pointers and occupancy. Flush outranks enqueue and dequeue;
    // the entry contents are cleared on reset so the outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_enq) begin
                mem[wr_ptr] <= decoded;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign A    = head.a;
    assign B    = head.b;
    assign Op   = head.op;
    assign Cin  = head.cin;
    assign invA = head.inv_a;
    assign invB = head.inv_b;
    assign sign = head.sign;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue
// Self-checking bench for alu_issue_queue. Stimulus pushes the expected
// issue packet of every accepted instruction into a scoreboard queue; a
// separate monitor compares the head outputs and handshakes every cycle and
// pops on each dequeue.
module tb_alu_issue_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_rs;
    logic [15:0] in_rt;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        ex_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Op;
    logic        Cin;
    logic        invA;
    logic        invB;
    logic        sign;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] op;
        logic        cin;
        logic        inv_a;
        logic        inv_b;
        logic        sign;
    } exp_t;

    exp_t sb [$];
    int   check_count = 0;
    int   pass_count  = 0;

    alu_issue_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .ex_ready  (ex_ready),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .Cin       (Cin),
        .invA      (invA),
        .invB      (invB),
        .sign      (sign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decode expressed through opcode ranges and instruction
    // classes rather than a per-opcode table.
    function automatic exp_t ref_decode(input logic [15:0] instr, input logic [15:0] rs,
                                        input logic [15:0] rt, input logic [15:0] imm);
        exp_t e;
        int   opc;
        int   fn;
        bit   is_sub;
        bit   is_andn;
        bit   is_cmp;
        opc     = int'(instr[15:11]);
        fn      = int'(instr[1:0]);
        is_sub  = (opc == 9) || (opc == 27 && fn == 1);
        is_andn = (opc == 11) || (opc == 27 && fn == 3);
        is_cmp  = (opc >= 28 && opc <= 30);
        e.a     = (opc == 18) ? 16'((int'(rs) * 256) % 65536) : rs;
        e.b     = (opc >= 26) ? rt : imm;
        e.op    = instr;
        e.cin   = is_sub || is_cmp;
        e.inv_a = is_sub;
        e.inv_b = is_andn || is_cmp;
        e.sign  = (opc != 31);
        return e;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        else
            pass_count++;
    endtask

    // One cycle of stimulus: drive after the falling edge, then record the
    // expected packet just before the rising edge if the queue accepts it.
    task automatic apply_stimulus(input logic v, input logic [15:0] instr,
                                  input logic [15:0] rs, input logic [15:0] rt,
                                  input logic [15:0] imm, input logic ex, input logic fl);
        @(negedge clk);
        in_valid = v;
        in_instr = instr;
        in_rs    = rs;
        in_rt    = rt;
        in_imm   = imm;
        ex_ready = ex;
        flush    = fl;
        #3;
        if (rst_n) begin
            if (fl)
                sb.delete();
            else if (v && in_ready)
                sb.push_back(ref_decode(instr, rs, rt, imm));
        end
    endtask

    task automatic idle(input logic ex);
        apply_stimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, ex, 1'b0);
    endtask

    // Monitor: handshake flags against scoreboard occupancy, then head
    // contents against the oldest expected packet; pop on dequeue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                check_output("in_ready", 64'(in_ready), 64'(sb.size() < 2));
                check_output("out_valid", 64'(out_valid), 64'(sb.size() > 0));
            end
            #2;
            if (rst_n && !flush && out_valid && sb.size() > 0) begin
                check_output("head_packet", 64'({A, B, Op, Cin, invA, invB, sign}), 64'(sb[0]));
                if (ex_ready)
                    void'(sb.pop_front());
            end
        end
    end

    logic [4:0] op_pool [16];

    initial begin
        logic [15:0] add1;
        logic [15:0] add2;
        logic [15:0] add3;
        logic [15:0] r_instr;

        op_pool = '{5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10100, 5'b10111,
                    5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b11010, 5'b11011,
                    5'b11100, 5'b11110, 5'b11111, 5'b00110};

        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_rs    = '0;
        in_rt    = '0;
        in_imm   = '0;
        ex_ready = 1'b0;
        #2;
        check_output("reset_in_ready", 64'(in_ready), 64'd1);
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_outputs", 64'({A, B, Op, Cin, invA, invB, sign}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // SUBI with rs=3, imm=5 appears the very next cycle.
        apply_stimulus(1'b1, 16'b01001_000_000_00101, 16'd3, 16'd0, 16'd5, 1'b1, 1'b0);
        idle(1'b0);
        check_output("subi_out_valid", 64'(out_valid), 64'd1);
        check_output("subi_ctrl", 64'({invA, Cin}), 64'b11);
        check_output("subi_a", 64'(A), 64'd3);
        check_output("subi_b", 64'(B), 64'd5);
        idle(1'b1);

        // SLBI shifts the low byte of rs into the high byte.
        apply_stimulus(1'b1, {5'b10010, 11'h0CD}, 16'h12AB, 16'h0000, 16'h00CD, 1'b0, 1'b0);
        idle(1'b0);
        check_output("slbi_a", 64'(A), 64'hAB00);
        check_output("slbi_b", 64'(B), 64'h00CD);
        check_output("slbi_ctrl", 64'({invA, invB, Cin}), 64'b000);
        idle(1'b1);

        // Three back-to-back ADDs with execute stalled.
        add1 = {5'b11011, 9'd1, 2'b00};
        add2 = {5'b11011, 9'd2, 2'b00};
        add3 = {5'b11011, 9'd3, 2'b00};
        apply_stimulus(1'b1, add1, 16'd10, 16'd11, 16'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, add2, 16'd20, 16'd21, 16'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, add3, 16'd30, 16'd31, 16'd0, 1'b0, 1'b0);
        check_output("full_in_ready", 64'(in_ready), 64'd0);
        check_output("frozen_op", 64'(Op), 64'(add1));
        idle(1'b0);
        check_output("frozen_a", 64'(A), 64'd10);

        // Full queue: dequeue with a concurrent offer, which is refused.
        apply_stimulus(1'b1, add3, 16'd30, 16'd31, 16'd0, 1'b1, 1'b0);
        check_output("full_drain_in_ready", 64'(in_ready), 64'd0);
        idle(1'b0);
        check_output("after_drain_in_ready", 64'(in_ready), 64'd1);
        check_output("fifo_order_op", 64'(Op), 64'(add2));
        idle(1'b1);
        idle(1'b0);
        check_output("drained_out_valid", 64'(out_valid), 64'd0);

        // Flush with a full queue and a same-cycle offer.
        apply_stimulus(1'b1, add1, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0);
        apply_stimulus(1'b1, add2, 16'd4, 16'd5, 16'd6, 1'b0, 1'b0);
        apply_stimulus(1'b1, add3, 16'd7, 16'd8, 16'd9, 1'b1, 1'b1);
        idle(1'b0);
        check_output("flush_out_valid", 64'(out_valid), 64'd0);
        check_output("flush_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset between edges with one entry queued.
        apply_stimulus(1'b1, add1, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_output("async_reset_out_valid", 64'(out_valid), 64'd0);
        check_output("async_reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // First enqueue after reset behaves as into an empty queue.
        apply_stimulus(1'b1, {5'b11111, 11'h001}, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);
        idle(1'b0);
        check_output("post_reset_out_valid", 64'(out_valid), 64'd1);
        check_output("post_reset_sco", 64'({B, sign}), 64'({16'h2222, 1'b0}));
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r_instr        = 16'($urandom);
            r_instr[15:11] = op_pool[$urandom_range(0, 15)];
            apply_stimulus(1'($urandom_range(0, 3) != 0), r_instr, 16'($urandom),
                           16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 4; i++)
            idle(1'b1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 flush  input  1  synchronous discard of all queued entries.
REQ-004 in_valid  input  1  decode stage offers an instruction.
REQ-005 in_ready  output  1  queue can accept this cycle.
REQ-006 in_instr  input  16  raw instruction word.
REQ-007 in_rs, in_rt, in_imm  input  16 each  Rs data, Rt data, extended immediate.
REQ-008 out_valid  output  1  head entry presented to execute.
REQ-009 ex_ready  input  1  execute consumes head this cycle.
REQ-010 A, B  output  16 each  ALU operands.
REQ-011 Op  output  16  instruction forwarded to ALU Op port.
REQ-012 Cin, invA, invB, sign  output  1 each  ALU control bits.

Function
REQ-013 The block shall be a 2-entry FIFO of fully decoded ALU issue packets, decoding at enqueue time.
REQ-014 Enqueue shall occur when in_valid & in_ready; dequeue when out_valid & ex_ready.
REQ-015 in_ready shall equal (count < 2), registered-state only, with no combinational dependence on ex_ready.
REQ-016 out_valid shall equal (count > 0); A/B/Op/control outputs shall reflect the head entry directly from registers.
REQ-017 Latency: an instruction accepted in cycle N shall appear at the outputs with out_valid=1 in cycle N+1 when the queue was empty.
REQ-018 Simultaneous enqueue and dequeue with count=1 shall leave count=1, with the new entry at the head next cycle.
REQ-019 With count=2, enqueue shall be refused (in_ready=0) even when ex_ready=1; a dequeue shall occur and count shall become 1.
REQ-020 Read/write pointers shall be 1 bit and wrap 1->0; FIFO order shall be preserved.
REQ-021 Outputs shall hold stable while out_valid=1 and ex_ready=0.
REQ-022 flush=1 shall set count=0 and ignore any same-cycle enqueue; flush shall take priority over every other event.
REQ-023 Decode, keyed on instr[15:11]; defaults A=rs, B=imm, invA=invB=Cin=0, sign=1:
- 01000 ADDI: none beyond defaults.
- 01001 SUBI: invA=1, Cin=1.
- 01010 XORI: none beyond defaults.
- 01011 ANDNI: invB=1.
- 101xx shift-immediate: B=imm.
- 10000/10001/10011 ST/LD/STU: A=rs, B=imm.
- 10010 SLBI: A={rs[7:0],8'h00}, B=imm.
- 11010 shift-register: B=rt.
- 11011 funct instr[1:0]: B=rt; 00 ADD; 01 SUB invA=1, Cin=1; 10 XOR; 11 ANDN invB=1.
- 11100/11101/11110 SEQ/SLT/SLE: B=rt, invB=1, Cin=1.
- 11111 SCO: B=rt, sign=0.
- All other opcodes: defaults.
REQ-024 Op shall be the accepted in_instr, unmodified.

Reset
REQ-025 While rst_n=0, the block shall immediately set count, pointers, out_valid, A, B, Op, Cin, invA, invB and sign to 0 and set in_ready to 1.
REQ-026 Reset asserted mid-transfer shall discard all entries; the first enqueue after release shall be treated as into an empty queue.

Verification
REQ-027 Instruction 16'b01001_xxx_xxx_00101, rs=3, imm=5, ex_ready=1: next cycle out_valid=1, invA=1, Cin=1, A=3, B=5.
REQ-028 Hold ex_ready=0 and enqueue three back-to-back ADDs: in_ready=0 after two; the third is held; outputs stay frozen on the first ADD.
REQ-029 With count=2, pulse ex_ready=1 together with in_valid=1: in_ready stays 0 and count goes to 1; entries drain in FIFO order.
REQ-030 SLBI with rs=16'h12AB, imm=16'h00CD: A=16'hAB00, B=16'h00CD, invA=invB=Cin=0.
REQ-031 flush asserted together with in_valid and count=2: next cycle out_valid=0, in_ready=1, count=0.
REQ-032 Drive rst_n low asynchronously between clock edges with count=1: out_valid drops to 0 before the next clk edge.
